icebus_status_rx: RTL

Byte-level frame parser for status telemetry returning from the iCEboard motor boards over the UART link. It sits between the 8N1 UART byte receiver and the per-motor status registers of the iCEboard control block. It consumes received bytes, hunts for sync, and validates a fixed-length status frame with CRC-16. On a valid frame it presents the decoded motor index, encoder positions, displacement and current with a one-cycle strobe, and keeps good/bad frame counters for the communication-quality statistics.

---
 rtl/icebus_status_rx.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/icebus_status_rx.sv
// icebus_status_rx
// Byte-level parser for motor-board status telemetry arriving over the UART link.
// It hunts for the 0x55 0xAA sync pair and collects a 12-byte body (id + payload).
// It checks the CRC-16/CCITT-FALSE that follows the body, high byte first.
// A good frame with an in-range id updates the status fields and pulses status_valid.
// Counters of good and bad frames are kept for link-quality statistics.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   rx_data, rx_valid     received byte and its one-cycle strobe
//   status_valid          one-cycle pulse: status fields updated
//   motor                 id - 128 of the last good frame
//   encoder0_position     24-bit field, passed through bit-exact
//   encoder1_position     24-bit field, passed through bit-exact
//   displacement          24-bit field, passed through bit-exact
//   current               16-bit field, passed through bit-exact
//   crc_error             one-cycle pulse on a CRC mismatch
//   frames_ok             saturating count of accepted frames
//   frames_bad            saturating count of CRC errors, id errors and timeouts
module icebus_status_rx #(
  parameter int unsigned NUMBER_OF_MOTORS    = 8,
  parameter int unsigned BYTE_TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        status_valid,
  output logic [7:0]  motor,
  output logic [23:0] encoder0_position,
  output logic [23:0] encoder1_position,
  output logic [23:0] displacement,
  output logic [15:0] current,
  output logic        crc_error,
  output logic [15:0] frames_ok,
  output logic [15:0] frames_bad
);

  localparam int unsigned GAP_W = $clog2(BYTE_TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    HUNT0,
    HUNT1,
    PAYLOAD,
    CRC_HI,
    CRC_LO
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       crc_q, crc_d;
  logic [7:0]        crc_hi_q, crc_hi_d;
  logic [95:0]       payload_q, payload_d;
  logic [3:0]        idx_q, idx_d;
  logic [GAP_W-1:0]  gap_q, gap_d;

  logic              status_valid_q, status_valid_d;
  logic [7:0]        motor_q, motor_d;
  logic [23:0]       enc0_q, enc0_d;
  logic [23:0]       enc1_q, enc1_d;
  logic [23:0]       disp_q, disp_d;
  logic [15:0]       cur_q, cur_d;
  logic              crc_error_q, crc_error_d;
  logic [15:0]       frames_ok_q, frames_ok_d;
  logic [15:0]       frames_bad_q, frames_bad_d;

  logic [7:0]        id;
  logic              id_ok;
  logic              in_frame;
  logic              timeout;

  // One byte of CRC-16/CCITT-FALSE, MSB first, no reflection.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int unsigned i = 0; i < 8; i++) begin
      r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    end
    return r;
  endfunction

  assign id       = payload_q[95:88];
  assign id_ok    = id[7] && ({25'd0, id[6:0]} < NUMBER_OF_MOTORS);
  assign in_frame = (state_q == PAYLOAD) || (state_q == CRC_HI) || (state_q == CRC_LO);
  // A byte in the same cycle suppresses the timeout.
  assign timeout  = in_frame && !rx_valid && (gap_q == GAP_W'(BYTE_TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d        = state_q;
    crc_d          = crc_q;
    crc_hi_d       = crc_hi_q;
    payload_d      = payload_q;
    idx_d          = idx_q;
    gap_d          = gap_q;
    status_valid_d = 1'b0;
    crc_error_d    = 1'b0;
    motor_d        = motor_q;
    enc0_d         = enc0_q;
    enc1_d         = enc1_q;
    disp_d         = disp_q;
    cur_d          = cur_q;
    frames_ok_d    = frames_ok_q;
    frames_bad_d   = frames_bad_q;

    if (!in_frame || rx_valid) begin
      gap_d = '0;
    end else begin
      gap_d = gap_q + GAP_W'(1);
    end

    case (state_q)
      HUNT0: begin
        if (rx_valid && rx_data == 8'h55) state_d = HUNT1;
      end
      HUNT1: begin
        if (rx_valid) begin
          if (rx_data == 8'hAA) begin
            state_d = PAYLOAD;
            crc_d   = '1;
            idx_d   = '0;
          end else if (rx_data != 8'h55) begin
            state_d = HUNT0;
          end
        end
      end
      PAYLOAD: begin
        if (rx_valid) begin
          payload_d = {payload_q[87:0], rx_data};
          crc_d     = crc16_byte(crc_q, rx_data);
          idx_d     = idx_q + 4'd1;
          if (idx_q == 4'd11) state_d = CRC_HI;
        end
      end
      CRC_HI: begin
        if (rx_valid) begin
          crc_hi_d = rx_data;
          state_d  = CRC_LO;
        end
      end
      CRC_LO: begin
        if (rx_valid) begin
          state_d = HUNT0;
          if ({crc_hi_q, rx_data} == crc_q) begin
            if (id_ok) begin
              status_valid_d = 1'b1;
              motor_d        = {1'b0, id[6:0]};
              enc0_d         = payload_q[87:64];
              enc1_d         = payload_q[63:40];
              disp_d         = payload_q[39:16];
              cur_d          = payload_q[15:0];
              if (frames_ok_q != 16'hFFFF) frames_ok_d = frames_ok_q + 16'd1;
            end else begin
              if (frames_bad_q != 16'hFFFF) frames_bad_d = frames_bad_q + 16'd1;
            end
          end else begin
            crc_error_d = 1'b1;
            if (frames_bad_q != 16'hFFFF) frames_bad_d = frames_bad_q + 16'd1;
          end
        end
      end
      default: state_d = HUNT0;
    endcase

    if (timeout) begin
      state_d = HUNT0;
      gap_d   = '0;
      if (frames_bad_q != 16'hFFFF) frames_bad_d = frames_bad_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= HUNT0;
      crc_q          <= 16'hFFFF;
      crc_hi_q       <= '0;
      payload_q      <= '0;
      idx_q          <= '0;
      gap_q          <= '0;
      status_valid_q <= 1'b0;
      motor_q        <= '0;
      enc0_q         <= '0;
      enc1_q         <= '0;
      disp_q         <= '0;
      cur_q          <= '0;
      crc_error_q    <= 1'b0;
      frames_ok_q    <= '0;
      frames_bad_q   <= '0;
    end else begin
      state_q        <= state_d;
      crc_q          <= crc_d;
      crc_hi_q       <= crc_hi_d;
      payload_q      <= payload_d;
      idx_q          <= idx_d;
      gap_q          <= gap_d;
      status_valid_q <= status_valid_d;
      motor_q        <= motor_d;
      enc0_q         <= enc0_d;
      enc1_q         <= enc1_d;
      disp_q         <= disp_d;
      cur_q          <= cur_d;
      crc_error_q    <= crc_error_d;
      frames_ok_q    <= frames_ok_d;
      frames_bad_q   <= frames_bad_d;
    end
  end

  assign status_valid      = status_valid_q;
  assign motor             = motor_q;
  assign encoder0_position = enc0_q;
  assign encoder1_position = enc1_q;
  assign displacement      = disp_q;
  assign current           = cur_q;
  assign crc_error         = crc_error_q;
  assign frames_ok         = frames_ok_q;
  assign frames_bad        = frames_bad_q;

endmodule
